// File: rtl/itu656_stream_decoder.sv
// itu656_stream_decoder
//   Front-end decoder for an 8-bit ITU-R BT.656 byte stream. It finds SAV/EAV timing
//   reference codes and tracks F/V/H. It also splits active video into 4:2:2
//   {Y, Cb|Cr} samples with pixel/line coordinates. Output is gated by decoder lock.
//
//   Optional feature macro: ITU656_PROT_CHECK_EN
//     defined   -> timing codes failing the P3..P0 protection bits are ignored and counted
//     undefined -> every bit7=1 code is accepted, oProtErr_Cnt is tied to 0
//
// Parameters
//   H_ACTIVE      luma samples per active line; oX saturates at H_ACTIVE-1
// Ports
//   iCLK_27       27 MHz pixel clock, rising edge
//   iRST_N        asynchronous active-low reset
//   iTD_DATA      BT.656 byte stream
//   iTD_Stable    decoder lock; low forces IDLE and clears oX/oY
//   oYCbCr        {Y, C}; C is Cb for even oX, Cr for odd oX
//   oDVAL         one-cycle strobe per luma sample
//   oX, oY        sample index within line, active line index within field
//   oField        F bit of last accepted timing code
//   oVBlank       V bit of last accepted timing code
//   oSOL          pulse when an active SAV starts a line
//   oProtErr_Cnt  saturating count of rejected timing codes
module itu656_stream_decoder #(
    parameter int unsigned H_ACTIVE = 720
) (
    input  logic        iCLK_27,
    input  logic        iRST_N,
    input  logic [7:0]  iTD_DATA,
    input  logic        iTD_Stable,
    output logic [15:0] oYCbCr,
    output logic        oDVAL,
    output logic [9:0]  oX,
    output logic [9:0]  oY,
    output logic        oField,
    output logic        oVBlank,
    output logic        oSOL,
    output logic [7:0]  oProtErr_Cnt
);

    typedef enum logic [1:0] {StIdle, StBlank, StActive} state_e;

    state_e      state_q, state_d;
    logic [23:0] hist_q, hist_d;      // {oldest, middle, newest} previous bytes
    logic [1:0]  phase_q, phase_d;
    logic [7:0]  chroma_q, chroma_d;
    logic        first_q, first_d;    // no sample emitted yet in this line
    logic [15:0] ycbcr_q, ycbcr_d;
    logic        dval_q, dval_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        field_q, field_d;
    logic        vblank_q, vblank_d;
    logic        sol_q, sol_d;

    logic        code_det, code_ok, preamble, x_last;
    logic        f_bit, v_bit, h_bit;
    logic [9:0]  y_inc;

    assign code_det = (hist_q == 24'hFF_0000) && iTD_DATA[7];
    assign f_bit    = iTD_DATA[6];
    assign v_bit    = iTD_DATA[5];
    assign h_bit    = iTD_DATA[4];
    assign x_last   = (x_q == 10'(H_ACTIVE - 1));
    assign y_inc    = (y_q == 10'h3FF) ? y_q : y_q + 10'd1;

    // The 00 bytes of a preamble are never video data. A leading FF cannot be told apart
    // from data without lookahead. In a full-length line it falls after oX saturates.
    assign preamble = ((hist_q[7:0] == 8'hFF) && (iTD_DATA == 8'h00)) ||
                      ((hist_q[15:0] == 16'hFF00) && (iTD_DATA == 8'h00));

`ifdef ITU656_PROT_CHECK_EN
    logic       prot_ok;
    logic [7:0] err_q;

    assign prot_ok = iTD_DATA[3:0] == {v_bit ^ h_bit, f_bit ^ h_bit, f_bit ^ v_bit,
                                       f_bit ^ v_bit ^ h_bit};
    assign code_ok = code_det && prot_ok;

    always_ff @(posedge iCLK_27 or negedge iRST_N) begin
        if (!iRST_N) begin
            err_q <= 8'd0;
        end else if (code_det && !prot_ok && err_q != 8'hFF) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign oProtErr_Cnt = err_q;
`else
    assign code_ok      = code_det;
    assign oProtErr_Cnt = 8'd0;
`endif

    always_comb begin
        state_d  = state_q;
        hist_d   = {hist_q[15:0], iTD_DATA};
        phase_d  = phase_q;
        chroma_d = chroma_q;
        first_d  = first_q;
        ycbcr_d  = ycbcr_q;
        dval_d   = 1'b0;
        x_d      = x_q;
        y_d      = y_q;
        field_d  = field_q;
        vblank_d = vblank_q;
        sol_d    = 1'b0;

        if (!iTD_Stable) begin
            state_d = StIdle;
            x_d     = 10'd0;
            y_d     = 10'd0;
        end else if (code_ok) begin
            field_d  = f_bit;
            vblank_d = v_bit;
            if (state_q == StIdle) begin
                state_d = StBlank;
            end else if (h_bit) begin
                if (state_q == StActive) begin
                    state_d = StBlank;
                    y_d     = y_inc;
                end
            end else if (v_bit) begin
                state_d = StBlank;
            end else begin
                // Active SAV; a SAV while already active means the EAV was lost.
                if (state_q == StActive) y_d = y_inc;
                state_d = StActive;
                sol_d   = 1'b1;
                phase_d = 2'd0;
                x_d     = 10'd0;
                first_d = 1'b1;
            end
            if (!h_bit && v_bit) y_d = 10'd0;
        end else if (state_q == StActive && !code_det && !preamble) begin
            phase_d = phase_q + 2'd1;
            if (!phase_q[0]) begin
                chroma_d = iTD_DATA;
            end else if (first_q || !x_last) begin
                ycbcr_d = {iTD_DATA, chroma_q};
                dval_d  = 1'b1;
                first_d = 1'b0;
                x_d     = first_q ? 10'd0 : x_q + 10'd1;
            end
        end
    end

    always_ff @(posedge iCLK_27 or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= StIdle;
            hist_q   <= 24'd0;
            phase_q  <= 2'd0;
            chroma_q <= 8'd0;
            first_q  <= 1'b1;
            ycbcr_q  <= 16'd0;
            dval_q   <= 1'b0;
            x_q      <= 10'd0;
            y_q      <= 10'd0;
            field_q  <= 1'b0;
            vblank_q <= 1'b1;
            sol_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            phase_q  <= phase_d;
            chroma_q <= chroma_d;
            first_q  <= first_d;
            ycbcr_q  <= ycbcr_d;
            dval_q   <= dval_d;
            x_q      <= x_d;
            y_q      <= y_d;
            field_q  <= field_d;
            vblank_q <= vblank_d;
            sol_q    <= sol_d;
        end
    end

    assign oYCbCr  = ycbcr_q;
    assign oDVAL   = dval_q;
    assign oX      = x_q;
    assign oY      = y_q;
    assign oField  = field_q;
    assign oVBlank = vblank_q;
    assign oSOL    = sol_q;

endmodule
